// File: rtl/input_interface_if.sv
// Byte-in / block-out bundle between the host, input_interface and the round engine.
// Key ports are present only when KEY_LOAD_EN is defined.
interface input_interface_if #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BLOCK_BYTES = 16
);
    localparam int unsigned BLOCK_W = DATA_W * BLOCK_BYTES;

    logic [DATA_W-1:0]  data_in;
    logic               data_valid;
    logic               input_ready;
    logic               engine_ready;
    logic [BLOCK_W-1:0] plaintext;
    logic               plaintext_valid;
    logic               overrun;
`ifdef KEY_LOAD_EN
    logic               key_load;
    logic [BLOCK_W-1:0] key_out;
    logic               key_valid;

    // Host and engine side of the link.
    modport master (
        output data_in, data_valid, engine_ready, key_load,
        input  input_ready, plaintext, plaintext_valid, overrun, key_out, key_valid
    );

    // Block assembler side of the link.
    modport slave (
        input  data_in, data_valid, engine_ready, key_load,
        output input_ready, plaintext, plaintext_valid, overrun, key_out, key_valid
    );
`else
    // Host and engine side of the link.
    modport master (
        output data_in, data_valid, engine_ready,
        input  input_ready, plaintext, plaintext_valid, overrun
    );

    // Block assembler side of the link.
    modport slave (
        input  data_in, data_valid, engine_ready,
        output input_ready, plaintext, plaintext_valid, overrun
    );
`endif
endinterface

// File: rtl/input_interface.sv
// Byte-serial AES front end: packs 16 host bytes (first byte MSB) into a 128-bit block and
// hands it to the engine through a one-deep valid/ready slot. Optional key path: KEY_LOAD_EN.
module input_interface #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned BLOCK_BYTES = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input_interface_if.slave bus
);
    localparam int unsigned      BLOCK_W  = DATA_W * BLOCK_BYTES;
    localparam int unsigned      CNT_W    = $clog2(BLOCK_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_FULL    = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [BLOCK_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_input_ready;
    logic [BLOCK_W-1:0] r_plaintext;
    logic               r_pt_valid;
    logic               r_overrun;

    logic               w_accept;
    logic               w_last_byte;
    logic               w_slot_free;
    logic               w_transfer;
    logic               w_key_fire;
    logic               w_block_done;

`ifdef KEY_LOAD_EN
    logic               r_key_tag;
    logic [BLOCK_W-1:0] r_key_out;
    logic               r_key_valid;
`endif

    assign w_accept    = bus.data_valid & r_input_ready;
    assign w_last_byte = w_accept && (r_cnt == LAST_IDX);
    // Slot can take a new block if empty or if the engine drains it on this same edge.
    assign w_slot_free = ~r_pt_valid | bus.engine_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: if (w_last_byte)  w_next_state = S_FULL;
            S_FULL:    if (w_block_done) w_next_state = S_COLLECT;
            default:   w_next_state = S_COLLECT;
        endcase
    end

    // Output decode: where a completed block goes this cycle.
    always_comb begin
        w_transfer = 1'b0;
        w_key_fire = 1'b0;
        if (r_state == S_FULL) begin
`ifdef KEY_LOAD_EN
            // Key blocks bypass the slot and never wait on the engine.
            if (r_key_tag) begin
                w_key_fire = 1'b1;
            end else begin
                w_transfer = w_slot_free;
            end
`else
            w_transfer = w_slot_free;
`endif
        end
        w_block_done = w_transfer | w_key_fire;
    end

    // Byte assembly, counter and ready.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_shift       <= '0;
            r_cnt         <= '0;
            r_input_ready <= 1'b0;
        end else begin
            r_input_ready <= (w_next_state == S_COLLECT);
            if (w_accept) begin
                r_shift <= {r_shift[BLOCK_W-DATA_W-1:0], bus.data_in};
                r_cnt   <= r_cnt + CNT_W'(1);
            end else if (w_block_done) begin
                r_cnt   <= '0;
            end
        end
    end

    // Holding slot toward the engine.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_plaintext <= '0;
            r_pt_valid  <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_plaintext <= r_shift;
                r_pt_valid  <= 1'b1;
            end else if (r_pt_valid && bus.engine_ready) begin
                r_pt_valid  <= 1'b0;
            end
        end
    end

    // Sticky protocol error: a byte offered while not ready is dropped.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_overrun <= 1'b0;
        end else if (bus.data_valid && !r_input_ready) begin
            r_overrun <= 1'b1;
        end
    end

`ifdef KEY_LOAD_EN
    // Key tag latched with byte 0; key output strobed for one cycle.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_key_tag   <= 1'b0;
            r_key_out   <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= w_key_fire;
            if (w_key_fire) begin
                r_key_out <= r_shift;
            end
            if (w_accept && (r_cnt == '0)) begin
                r_key_tag <= bus.key_load;
            end
        end
    end

    assign bus.key_out   = r_key_out;
    assign bus.key_valid = r_key_valid;
`endif

    assign bus.input_ready     = r_input_ready;
    assign bus.plaintext       = r_plaintext;
    assign bus.plaintext_valid = r_pt_valid;
    assign bus.overrun         = r_overrun;

endmodule

// File: tb/tb_input_interface.sv
// Directed + random bench for input_interface; reference model works on a byte queue and
// whole-block values. Define KEY_LOAD_EN to also exercise the key path.
module tb_input_interface;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BLOCK_W     = DATA_W * BLOCK_BYTES;

    logic clk = 1'b0;
    logic rst_ = 1'b0;

    input_interface_if #(.DATA_W(DATA_W), .BLOCK_BYTES(BLOCK_BYTES)) bus ();

    input_interface #(.DATA_W(DATA_W), .BLOCK_BYTES(BLOCK_BYTES)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [7:0]   m_q[$];
    bit           m_full;
    bit           m_slot_v;
    bit           m_ir;
    bit           m_ovr;
    logic [127:0] m_slot;
`ifdef KEY_LOAD_EN
    bit           m_tag;
    bit           m_key_v;
    logic [127:0] m_key;
    logic         t_key_load = 1'b0;
`endif

    function automatic logic [127:0] pack_q();
        logic [127:0] b = '0;
        for (int i = 0; i < m_q.size(); i++) b[127-8*i -: 8] = m_q[i];
        return b;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_full   = 0;
        m_slot_v = 0;
        m_ir     = 0;
        m_ovr    = 0;
        m_slot   = '0;
`ifdef KEY_LOAD_EN
        m_tag    = 0;
        m_key_v  = 0;
        m_key    = '0;
`endif
    endtask

    // One clock edge of the reference behaviour, using pre-edge values.
    task automatic model_edge(input logic dv, input logic [7:0] d, input logic er);
        bit ir0     = m_ir;
        bit sv0     = m_slot_v;
        bit full0   = m_full;
        bit to_slot = 0;
`ifdef KEY_LOAD_EN
        bit to_key  = 0;
        m_key_v = 0;
`endif
        if (full0) begin
`ifdef KEY_LOAD_EN
            if (m_tag) to_key = 1; else
`endif
            if (!sv0 || er) to_slot = 1;
        end
        if (to_slot) begin
            m_slot   = pack_q();
            m_slot_v = 1;
            m_q.delete();
            m_full   = 0;
        end else if (sv0 && er) begin
            m_slot_v = 0;
        end
`ifdef KEY_LOAD_EN
        if (to_key) begin
            m_key   = pack_q();
            m_key_v = 1;
            m_q.delete();
            m_full  = 0;
        end
`endif
        if (dv) begin
            if (ir0) begin
`ifdef KEY_LOAD_EN
                if (m_q.size() == 0) m_tag = t_key_load;
`endif
                m_q.push_back(d);
                if (m_q.size() == BLOCK_BYTES) m_full = 1;
            end else begin
                m_ovr = 1;
            end
        end
        m_ir = !m_full;
    endtask

    task automatic compare_all();
        check("input_ready",     bus.input_ready,     m_ir);
        check("plaintext_valid", bus.plaintext_valid, m_slot_v);
        check("plaintext",       bus.plaintext,       m_slot);
        check("overrun",         bus.overrun,         m_ovr);
`ifdef KEY_LOAD_EN
        check("key_valid",       bus.key_valid,       m_key_v);
        check("key_out",         bus.key_out,         m_key);
`endif
    endtask

    task automatic step(input logic dv, input logic [7:0] d, input logic er);
        bus.data_valid   = dv;
        bus.data_in      = d;
        bus.engine_ready = er;
`ifdef KEY_LOAD_EN
        bus.key_load     = t_key_load;
`endif
        @(posedge clk);
        model_edge(dv, d, er);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic er);
        repeat (n) step(1'b0, 8'h00, er);
    endtask

    task automatic send_block(input logic [127:0] blk, input logic er);
        for (int i = 0; i < 16; i++) step(1'b1, blk[127-8*i -: 8], er);
    endtask

`ifdef KEY_LOAD_EN
    task automatic send_key_block(input logic [127:0] blk, input logic er);
        for (int i = 0; i < 16; i++) begin
            t_key_load = (i == 0);
            step(1'b1, blk[127-8*i -: 8], er);
        end
        t_key_load = 1'b0;
    endtask
`endif

    task automatic async_reset();
        bus.data_valid   = 1'b0;
        bus.engine_ready = 1'b0;
        rst_ = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("rst_input_ready", bus.input_ready,     1'b0);
        check("rst_pt_valid",    bus.plaintext_valid, 1'b0);
        check("rst_plaintext",   bus.plaintext,       128'h0);
        check("rst_overrun",     bus.overrun,         1'b0);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] blk_a, blk_b, blk_c, blk_t2, blk_tmp;
        logic         dv, er;

        bus.data_valid   = 1'b0;
        bus.data_in      = 8'h00;
        bus.engine_ready = 1'b0;
`ifdef KEY_LOAD_EN
        bus.key_load     = 1'b0;
`endif
        model_reset();
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        idle(1, 1'b0);
        check("ready_after_release", bus.input_ready, 1'b1);

        // T1: reset with 7 bytes collected, then a clean block.
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b1);
        async_reset();
        idle(1, 1'b1);
        blk_a = rand_block();
        send_block(blk_a, 1'b1);
        idle(1, 1'b1);
        check("t1_clean_block", bus.plaintext, blk_a);
        idle(2, 1'b1);

        // T2: bytes 00..0F, engine always ready.
        blk_t2 = 128'h000102030405060708090A0B0C0D0E0F;
        send_block(blk_t2, 1'b1);
        check("t2_valid_not_yet", bus.plaintext_valid, 1'b0);
        check("t2_ready_low_full", bus.input_ready, 1'b0);
        idle(1, 1'b1);
        check("t2_valid_rise", bus.plaintext_valid, 1'b1);
        check("t2_plaintext", bus.plaintext, 128'h000102030405060708090A0B0C0D0E0F);
        idle(1, 1'b1);
        check("t2_valid_one_cycle", bus.plaintext_valid, 1'b0);

        // T3: backpressure holds A, B waits in FULL.
        blk_a = rand_block();
        blk_b = rand_block();
        send_block(blk_a, 1'b0);
        idle(1, 1'b0);
        send_block(blk_b, 1'b0);
        idle(3, 1'b0);
        check("t3_ready_low", bus.input_ready, 1'b0);
        check("t3_a_held", bus.plaintext, blk_a);
        step(1'b0, 8'h00, 1'b1);
        check("t3_b_loaded", bus.plaintext, blk_b);
        check("t3_valid_stays", bus.plaintext_valid, 1'b1);

        // T4: byte 0x55 offered while not ready is dropped.
        blk_c = rand_block();
        send_block(blk_c, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        check("t4_overrun", bus.overrun, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("t4_c_loaded", bus.plaintext, blk_c);
        blk_tmp = rand_block();
        send_block(blk_tmp, 1'b1);
        idle(1, 1'b1);
        check("t4_next_block_clean", bus.plaintext, blk_tmp);
        idle(2, 1'b1);

        // T5: engine drains the slot on the very first FULL cycle.
        blk_a = rand_block();
        blk_b = rand_block();
        send_block(blk_a, 1'b0);
        idle(1, 1'b0);
        send_block(blk_b, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("t5_no_bubble_valid", bus.plaintext_valid, 1'b1);
        check("t5_switch", bus.plaintext, blk_b);
        check("t5_ready_back", bus.input_ready, 1'b1);

`ifdef KEY_LOAD_EN
        // T6: key block bypasses an occupied slot.
        send_key_block(128'h2B7E151628AED2A6ABF7158809CF4F3C, 1'b0);
        idle(1, 1'b0);
        check("t6_key_valid", bus.key_valid, 1'b1);
        check("t6_key_out", bus.key_out, 128'h2B7E151628AED2A6ABF7158809CF4F3C);
        check("t6_slot_untouched", bus.plaintext, blk_b);
        check("t6_pt_valid_kept", bus.plaintext_valid, 1'b1);
        idle(1, 1'b0);
        check("t6_key_strobe_once", bus.key_valid, 1'b0);
`endif
        idle(1, 1'b1);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            dv = ($urandom_range(0, 3) != 0);
            er = 1'($urandom_range(0, 1));
`ifdef KEY_LOAD_EN
            t_key_load = ($urandom_range(0, 7) == 0);
`endif
            step(dv, 8'($urandom), er);
        end
`ifdef KEY_LOAD_EN
        t_key_load = 1'b0;
`endif

        async_reset();
        idle(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
